// File: rtl/branch_resolve_pkg.sv
// Shared branch-unit definitions: op codes, jump-type codes, bus layout, FSM states.
package branch_resolve_pkg;

  localparam logic [3:0] BR_NONE     = 4'd0;
  localparam logic [3:0] BR_BEQ      = 4'd1;
  localparam logic [3:0] BR_BNE      = 4'd2;
  localparam logic [3:0] BR_BLT      = 4'd3;
  localparam logic [3:0] BR_BGE      = 4'd4;
  localparam logic [3:0] BR_BLTU     = 4'd5;
  localparam logic [3:0] BR_BGEU     = 4'd6;
  localparam logic [3:0] BR_B        = 4'd7;
  localparam logic [3:0] BR_BL       = 4'd8;
  localparam logic [3:0] BR_JIRL     = 4'd9;
  localparam logic [3:0] BR_JIRL_RET = 4'd10;

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_CALL = 2'b01;
  localparam logic [1:0] JT_RET  = 2'b10;

  localparam int BPU_ES_BUS_WD = 72;

  typedef enum logic {S_IDLE, S_PEND} state_t;

  // Field order is the bus order, msb first.
  typedef struct packed {
    logic        flush;
    logic        in_excp;
    logic        is_etrn;
    logic [31:0] pc;
    logic        may_jump;
    logic        need_jump;
    logic        pre_fail;
    logic [31:0] right_target;
    logic [1:0]  jump_type;
  } es_bus_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/branch_resolve_br_eval.sv
// Per-slot branch evaluation: actual direction, actual target, call/return type, mispredict.
module br_eval
  import branch_resolve_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] pc,
  input  logic [31:0] rj,
  input  logic [31:0] rd,
  input  logic [31:0] offs,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        need_jump,
  output logic [31:0] right_target,
  output logic [1:0]  jump_type,
  output logic        pre_fail
);

  // Direction, target and type from the op; unknown codes behave as no branch.
  always_comb begin
    need_jump = 1'b0;
    case (op)
      BR_BEQ:                             need_jump = (rj == rd);
      BR_BNE:                             need_jump = (rj != rd);
      BR_BLT:                             need_jump = ($signed(rj) <  $signed(rd));
      BR_BGE:                             need_jump = ($signed(rj) >= $signed(rd));
      BR_BLTU:                            need_jump = (rj <  rd);
      BR_BGEU:                            need_jump = (rj >= rd);
      BR_B, BR_BL, BR_JIRL, BR_JIRL_RET:  need_jump = 1'b1;
      default:                            need_jump = 1'b0;
    endcase
    right_target = (op == BR_JIRL || op == BR_JIRL_RET) ? rj + offs : pc + offs;
    jump_type    = (op == BR_BL) ? JT_CALL : (op == BR_JIRL_RET) ? JT_RET : JT_NONE;
    pre_fail     = (pred_taken != need_jump) || (need_jump && (pred_target != right_target));
  end

endmodule

// File: rtl/branch_resolve.sv
// Dual-slot branch resolution: evaluates both slots, reports them to the BPU one
// cycle later, and holds a single redirect to fetch until it is accepted.
module branch_resolve
  import branch_resolve_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid1,
  input  logic        es_valid2,
  input  logic [31:0] es_pc1,
  input  logic [31:0] es_pc2,
  input  logic [3:0]  es_op1,
  input  logic [3:0]  es_op2,
  input  logic [31:0] es_rj1,
  input  logic [31:0] es_rj2,
  input  logic [31:0] es_rd1,
  input  logic [31:0] es_rd2,
  input  logic [31:0] es_offs1,
  input  logic [31:0] es_offs2,
  input  logic        es_pred_taken1,
  input  logic        es_pred_taken2,
  input  logic [31:0] es_pred_target1,
  input  logic [31:0] es_pred_target2,
  input  logic        es_excp1,
  input  logic        es_excp2,
  input  logic        es_etrn1,
  input  logic        es_etrn2,
  input  logic        pipe_flush,
  output logic [BPU_ES_BUS_WD-1:0] bpu_es_bus1,
  output logic [BPU_ES_BUS_WD-1:0] bpu_es_bus2,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic [15:0] num_br,
  output logic [15:0] num_miss
);

  state_t      state, state_nx;
  es_bus_t     bus1_d, bus2_d, bus1_q, bus2_q;
  logic        need1, need2, pf1, pf2;
  logic [31:0] tgt1, tgt2, redir_tgt;
  logic [1:0]  jt1, jt2;
  logic        may1, may2, squash, red1, red2;
  logic [1:0]  br_inc, miss_inc;

  br_eval u_eval1 (
    .op(es_op1), .pc(es_pc1), .rj(es_rj1), .rd(es_rd1), .offs(es_offs1),
    .pred_taken(es_pred_taken1), .pred_target(es_pred_target1),
    .need_jump(need1), .right_target(tgt1), .jump_type(jt1), .pre_fail(pf1)
  );

  br_eval u_eval2 (
    .op(es_op2), .pc(es_pc2), .rj(es_rj2), .rd(es_rd2), .offs(es_offs2),
    .pred_taken(es_pred_taken2), .pred_target(es_pred_target2),
    .need_jump(need2), .right_target(tgt2), .jump_type(jt2), .pre_fail(pf2)
  );

  // Slot qualification: anything arriving while a redirect is pending or being
  // flushed is wrong-path and must neither redirect nor be counted.
  always_comb begin
    may1      = es_valid1 && (es_op1 != BR_NONE) && (es_op1 <= BR_JIRL_RET);
    may2      = es_valid2 && (es_op2 != BR_NONE) && (es_op2 <= BR_JIRL_RET);
    squash    = (state == S_PEND) || pipe_flush;
    red1      = !squash && may1 && pf1 && !es_excp1 && !es_etrn1;
    red2      = !squash && !red1 && may2 && pf2 && !es_excp2 && !es_etrn2;
    redir_tgt = red1 ? (need1 ? tgt1 : es_pc1 + 32'd4)
                     : (need2 ? tgt2 : es_pc2 + 32'd4);
    br_inc    = {1'b0, !squash && may1} + {1'b0, !squash && !red1 && may2};
    miss_inc  = {1'b0, red1} + {1'b0, red2};
  end

  // Next bus contents; a slot younger than a redirecting slot is shown as non-branch.
  always_comb begin
    bus1_d       = '0;
    bus2_d       = '0;
    bus1_d.flush = pipe_flush;
    bus2_d.flush = pipe_flush;
    if (!squash) begin
      bus1_d.in_excp      = es_excp1;
      bus1_d.is_etrn      = es_etrn1;
      bus1_d.pc           = es_pc1;
      bus1_d.may_jump     = may1;
      bus1_d.need_jump    = need1;
      bus1_d.pre_fail     = pf1;
      bus1_d.right_target = tgt1;
      bus1_d.jump_type    = jt1;
      bus2_d.in_excp      = es_excp2;
      bus2_d.is_etrn      = es_etrn2;
      bus2_d.pc           = es_pc2;
      bus2_d.may_jump     = may2 && !red1;
      bus2_d.need_jump    = need2 && !red1;
      bus2_d.pre_fail     = pf2 && !red1;
      bus2_d.right_target = tgt2;
      bus2_d.jump_type    = jt2;
    end
  end

  // Redirect FSM next state; flush wins over a fresh redirect.
  always_comb begin
    state_nx = state;
    if (pipe_flush)                     state_nx = S_IDLE;
    else if (state == S_IDLE && (red1 || red2)) state_nx = S_PEND;
    else if (state == S_PEND && redir_ready)    state_nx = S_IDLE;
  end

  // State, registered buses, redirect request and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bus1_q      <= '0;
      bus2_q      <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      num_br      <= '0;
      num_miss    <= '0;
    end else begin
      state       <= state_nx;
      bus1_q      <= bus1_d;
      bus2_q      <= bus2_d;
      redir_valid <= (state_nx == S_PEND);
      if (state == S_IDLE && state_nx == S_PEND) redir_pc <= redir_tgt;
      num_br      <= sat_add(num_br, br_inc);
      num_miss    <= sat_add(num_miss, miss_inc);
    end
  end

  assign bpu_es_bus1 = bus1_q;
  assign bpu_es_bus2 = bus2_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a cycle-level reference model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 0, reset = 0;
  logic        es_valid1 = 0, es_valid2 = 0;
  logic [31:0] es_pc1 = 0, es_pc2 = 0;
  logic [3:0]  es_op1 = 0, es_op2 = 0;
  logic [31:0] es_rj1 = 0, es_rj2 = 0, es_rd1 = 0, es_rd2 = 0;
  logic [31:0] es_offs1 = 0, es_offs2 = 0;
  logic        es_pred_taken1 = 0, es_pred_taken2 = 0;
  logic [31:0] es_pred_target1 = 0, es_pred_target2 = 0;
  logic        es_excp1 = 0, es_excp2 = 0, es_etrn1 = 0, es_etrn2 = 0;
  logic        pipe_flush = 0, redir_ready = 0;
  logic [71:0] bpu_es_bus1, bpu_es_bus2;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [15:0] num_br, num_miss;

  int nvec = 0, nerr = 0;
  bit chk_en = 0;

  branch_resolve dut (
    .clk(clk), .reset(reset),
    .es_valid1(es_valid1), .es_valid2(es_valid2),
    .es_pc1(es_pc1), .es_pc2(es_pc2), .es_op1(es_op1), .es_op2(es_op2),
    .es_rj1(es_rj1), .es_rj2(es_rj2), .es_rd1(es_rd1), .es_rd2(es_rd2),
    .es_offs1(es_offs1), .es_offs2(es_offs2),
    .es_pred_taken1(es_pred_taken1), .es_pred_taken2(es_pred_taken2),
    .es_pred_target1(es_pred_target1), .es_pred_target2(es_pred_target2),
    .es_excp1(es_excp1), .es_excp2(es_excp2), .es_etrn1(es_etrn1), .es_etrn2(es_etrn2),
    .pipe_flush(pipe_flush),
    .bpu_es_bus1(bpu_es_bus1), .bpu_es_bus2(bpu_es_bus2),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .num_br(num_br), .num_miss(num_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [71:0] m_bus1 = 0, m_bus2 = 0;
  bit          m_pend = 0;
  logic [31:0] m_rpc = 0;
  int          m_br = 0, m_miss = 0;

  function automatic void judge(input logic [3:0] op, input logic [31:0] pc, rj, rd, offs,
                                input logic pt, input logic [31:0] ptgt,
                                output logic tk, output logic [31:0] tg,
                                output logic [1:0] ty, output logic miss);
    case (op)
      1: tk = rj == rd;
      2: tk = rj != rd;
      3: tk = $signed(rj) < $signed(rd);
      4: tk = !($signed(rj) < $signed(rd));
      5: tk = rj < rd;
      6: tk = !(rj < rd);
      7, 8, 9, 10: tk = 1;
      default: tk = 0;
    endcase
    tg   = (op == 9 || op == 10) ? rj + offs : pc + offs;
    ty   = (op == 8) ? 2'd1 : (op == 10) ? 2'd2 : 2'd0;
    miss = (pt != tk) || (tk && ptgt != tg);
  endfunction

  always @(posedge clk) begin
    logic tk1, tk2, ms1, ms2, v1, v2, r1, r2, sq;
    logic [31:0] tg1, tg2;
    logic [1:0]  ty1, ty2;
    if (reset) begin
      m_bus1 = 0; m_bus2 = 0; m_pend = 0; m_rpc = 0; m_br = 0; m_miss = 0;
    end else begin
      judge(es_op1, es_pc1, es_rj1, es_rd1, es_offs1, es_pred_taken1, es_pred_target1, tk1, tg1, ty1, ms1);
      judge(es_op2, es_pc2, es_rj2, es_rd2, es_offs2, es_pred_taken2, es_pred_target2, tk2, tg2, ty2, ms2);
      sq = m_pend || pipe_flush;
      v1 = es_valid1 && es_op1 >= 1 && es_op1 <= 10;
      v2 = es_valid2 && es_op2 >= 1 && es_op2 <= 10;
      r1 = !sq && v1 && ms1 && !es_excp1 && !es_etrn1;
      r2 = !sq && !r1 && v2 && ms2 && !es_excp2 && !es_etrn2;
      if (sq) begin
        m_bus1 = {pipe_flush, 71'd0};
        m_bus2 = {pipe_flush, 71'd0};
      end else begin
        m_bus1 = {pipe_flush, es_excp1, es_etrn1, es_pc1, v1, tk1, ms1, tg1, ty1};
        if (r1) m_bus2 = {pipe_flush, es_excp2, es_etrn2, es_pc2, 3'b000, tg2, ty2};
        else    m_bus2 = {pipe_flush, es_excp2, es_etrn2, es_pc2, v2, tk2, ms2, tg2, ty2};
        m_br   = m_br + int'(v1) + int'(v2 && !r1);
        m_miss = m_miss + int'(r1) + int'(r2);
        if (m_br > 65535)   m_br = 65535;
        if (m_miss > 65535) m_miss = 65535;
      end
      if (pipe_flush) m_pend = 0;
      else if (m_pend) begin
        if (redir_ready) m_pend = 0;
      end else if (r1 || r2) begin
        m_pend = 1;
        m_rpc  = r1 ? (tk1 ? tg1 : es_pc1 + 32'd4) : (tk2 ? tg2 : es_pc2 + 32'd4);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) if (chk_en) begin
    chk("bus1", bpu_es_bus1, m_bus1);
    chk("bus2", bpu_es_bus2, m_bus2);
    chk("redir_valid", {71'd0, redir_valid}, {71'd0, m_pend});
    chk("redir_pc", {40'd0, redir_pc}, {40'd0, m_rpc});
    chk("num_br", {56'd0, num_br}, {56'd0, m_br[15:0]});
    chk("num_miss", {56'd0, num_miss}, {56'd0, m_miss[15:0]});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    es_valid1 = 0; es_valid2 = 0; es_op1 = 0; es_op2 = 0;
    es_pc1 = 0; es_pc2 = 0; es_rj1 = 0; es_rj2 = 0; es_rd1 = 0; es_rd2 = 0;
    es_offs1 = 0; es_offs2 = 0; es_pred_taken1 = 0; es_pred_taken2 = 0;
    es_pred_target1 = 0; es_pred_target2 = 0;
    es_excp1 = 0; es_excp2 = 0; es_etrn1 = 0; es_etrn2 = 0;
    pipe_flush = 0; redir_ready = 0;
  endtask

  task automatic s1(input logic [3:0] op, input logic [31:0] pc, rj, rd, offs,
                    input logic pt, input logic [31:0] ptgt);
    es_valid1 = 1; es_op1 = op; es_pc1 = pc; es_rj1 = rj; es_rd1 = rd;
    es_offs1 = offs; es_pred_taken1 = pt; es_pred_target1 = ptgt;
  endtask

  task automatic s2(input logic [3:0] op, input logic [31:0] pc, rj, rd, offs,
                    input logic pt, input logic [31:0] ptgt);
    es_valid2 = 1; es_op2 = op; es_pc2 = pc; es_rj2 = rj; es_rd2 = rd;
    es_offs2 = offs; es_pred_taken2 = pt; es_pred_target2 = ptgt;
  endtask

  task automatic do_reset();
    clr_in(); reset = 1; step(); reset = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_bus1", bpu_es_bus1, 72'd0);
    chk("rst_rv", {71'd0, redir_valid}, 72'd0);
    chk("rst_nbr", {56'd0, num_br}, 72'd0);

    // Correctly predicted taken BEQ.
    s1(BR_BEQ, 32'h1000, 5, 5, 32'h40, 1, 32'h1040); step();
    chk("beq_need", {71'd0, bpu_es_bus1[35]}, 72'd1);
    chk("beq_pf", {71'd0, bpu_es_bus1[34]}, 72'd0);
    chk("beq_rv", {71'd0, redir_valid}, 72'd0);
    chk("beq_nbr", {56'd0, num_br}, 72'd1);
    clr_in(); step();

    // Mispredicted BLT, redirect held while fetch stalls.
    do_reset();
    s1(BR_BLT, 32'h2000, 32'hFFFF_FFFF, 0, 32'h10, 0, 0); step();
    chk("blt_pf", {71'd0, bpu_es_bus1[34]}, 72'd1);
    chk("blt_rpc", {40'd0, redir_pc}, 72'h2010);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pend_rv", {71'd0, redir_valid}, 72'd1);
      chk("pend_sq", bpu_es_bus1, 72'd0);
      chk("pend_nbr", {56'd0, num_br}, 72'd1);
    end
    redir_ready = 1; step();
    chk("ack_rv", {71'd0, redir_valid}, 72'd0);
    chk("ack_nbr", {56'd0, num_br}, 72'd1);
    clr_in(); step();

    // Slot1 not-taken mispredict wins over slot2.
    do_reset();
    s1(BR_BNE, 32'h3000, 7, 7, 32'h20, 1, 32'h3020);
    s2(BR_BL, 32'h3004, 0, 0, 32'h100, 0, 0); step();
    chk("pri_rpc", {40'd0, redir_pc}, 72'h3004);
    chk("pri_may2", {71'd0, bpu_es_bus2[36]}, 72'd0);
    chk("pri_miss", {56'd0, num_miss}, 72'd1);
    clr_in(); redir_ready = 1; step(); clr_in();

    // Return, then the same return under an exception.
    do_reset();
    s1(BR_JIRL_RET, 32'h4000, 32'h8000, 0, 0, 1, 32'h8000); step();
    chk("ret_jt", {70'd0, bpu_es_bus1[1:0]}, 72'd2);
    chk("ret_pf", {71'd0, bpu_es_bus1[34]}, 72'd0);
    es_excp1 = 1; es_pred_target1 = 32'h1234; step();
    chk("exc_rv", {71'd0, redir_valid}, 72'd0);
    chk("exc_bit", {71'd0, bpu_es_bus1[70]}, 72'd1);
    chk("exc_miss", {56'd0, num_miss}, 72'd0);
    clr_in(); step();

    // Flush while pending, alongside a new mispredict.
    do_reset();
    s1(BR_BLT, 32'h2000, 32'hFFFF_FFFF, 0, 32'h10, 0, 0); step();
    chk("fl_pend", {71'd0, redir_valid}, 72'd1);
    s1(BR_BEQ, 32'h6000, 3, 3, 32'h80, 0, 0); pipe_flush = 1; step();
    chk("fl_rv", {71'd0, redir_valid}, 72'd0);
    chk("fl_bus", bpu_es_bus1, {1'b1, 71'd0});
    pipe_flush = 0; step();
    chk("fl_idle", {71'd0, redir_valid}, 72'd1);
    chk("fl_rpc", {40'd0, redir_pc}, 72'h6080);
    clr_in(); redir_ready = 1; step(); clr_in();

    // Counter saturation, then reset while pending.
    do_reset();
    s1(BR_B, 32'h5000, 0, 0, 8, 1, 32'h5008);
    s2(BR_B, 32'h5004, 0, 0, 8, 1, 32'h500C);
    for (int i = 0; i < 32770; i++) step();
    chk("sat_nbr", {56'd0, num_br}, 72'hFFFF);
    clr_in();
    s1(BR_BLT, 32'h2000, 32'hFFFF_FFFF, 0, 32'h10, 0, 0); step();
    chk("mp_rv", {71'd0, redir_valid}, 72'd1);
    reset = 1; step(); reset = 0; clr_in();
    chk("rr_bus1", bpu_es_bus1, 72'd0);
    chk("rr_bus2", bpu_es_bus2, 72'd0);
    chk("rr_rv", {71'd0, redir_valid}, 72'd0);
    chk("rr_rpc", {40'd0, redir_pc}, 72'd0);
    chk("rr_cnt", {40'd0, num_br, num_miss}, 72'd0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
